// File: rtl/gpio_in_debouncer.sv
// rtl/gpio_in_debouncer.sv - per-bit synchroniser, debouncer, edge pulses and sticky change flags
module gpio_in_debouncer #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 500000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] sw_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] evt_o,
    input  logic [WIDTH-1:0] evt_clr_i
);

    // The counter saturates here and the level update fires instead of wrapping.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] sw_q, sw_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] evt_q, evt_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        sync1_d = raw_i;
        sync2_d = sync1_q;
        sw_d    = sw_q;
        rise_d  = '0;
        fall_d  = '0;
        evt_d   = evt_q & ~evt_clr_i;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != sw_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    sw_d[i]   = sync2_q[i];
                    rise_d[i] = sync2_q[i];
                    fall_d[i] = ~sync2_q[i];
                    // A new change outranks a clear arriving on the same edge.
                    evt_d[i]  = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sw_q    <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            evt_q   <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sw_q    <= sw_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            evt_q   <= evt_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_o   = sw_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign evt_o  = evt_q;

endmodule

// File: tb/tb_gpio_in_debouncer.sv
// tb/tb_gpio_in_debouncer.sv - directed bench for gpio_in_debouncer with STABLE_CYCLES=4
module tb_gpio_in_debouncer;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] raw_i = 8'h00;
    logic [7:0] evt_clr_i = 8'h00;
    logic [7:0] sw_o, rise_o, fall_o, evt_o;

    int checks = 0;
    int failures = 0;

    gpio_in_debouncer #(
        .WIDTH        (8),
        .STABLE_CYCLES(4)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .raw_i    (raw_i),
        .sw_o     (sw_o),
        .rise_o   (rise_o),
        .fall_o   (fall_o),
        .evt_o    (evt_o),
        .evt_clr_i(evt_clr_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic quiet(input string tag, input int n, input logic [7:0] sw_exp, input logic [7:0] evt_exp);
        for (int k = 0; k < n; k++) begin
            step(1);
            chk({tag, "_sw"}, sw_o, sw_exp);
            chk({tag, "_rise"}, rise_o, 8'h00);
            chk({tag, "_fall"}, fall_o, 8'h00);
            chk({tag, "_evt"}, evt_o, evt_exp);
        end
    endtask

    task automatic clean_reset();
        rst_i = 1'b1;
        raw_i = 8'h00;
        evt_clr_i = 8'h00;
        step(2);
        rst_i = 1'b0;
        step(3);
    endtask

    initial begin
        // reset with all inputs high, then release
        raw_i = 8'hFF;
        step(3);
        chk("rst_sw", sw_o, 8'h00);
        chk("rst_rise", rise_o, 8'h00);
        chk("rst_fall", fall_o, 8'h00);
        chk("rst_evt", evt_o, 8'h00);
        rst_i = 1'b0;
        quiet("rel_pre", 5, 8'h00, 8'h00);
        step(1);
        chk("rel_sw", sw_o, 8'hFF);
        chk("rel_rise", rise_o, 8'hFF);
        chk("rel_fall", fall_o, 8'h00);
        chk("rel_evt", evt_o, 8'hFF);
        step(1);
        chk("rel_rise_end", rise_o, 8'h00);
        chk("rel_sw_hold", sw_o, 8'hFF);

        // clean rise then fall on bit 0
        clean_reset();
        raw_i = 8'h01;
        quiet("b0r_pre", 5, 8'h00, 8'h00);
        step(1);
        chk("b0r_sw", sw_o, 8'h01);
        chk("b0r_rise", rise_o, 8'h01);
        chk("b0r_evt", evt_o, 8'h01);
        step(1);
        chk("b0r_rise_end", rise_o, 8'h00);
        raw_i = 8'h00;
        quiet("b0f_pre", 5, 8'h01, 8'h01);
        step(1);
        chk("b0f_sw", sw_o, 8'h00);
        chk("b0f_fall", fall_o, 8'h01);
        chk("b0f_rise", rise_o, 8'h00);
        chk("b0f_evt", evt_o, 8'h01);
        step(1);
        chk("b0f_fall_end", fall_o, 8'h00);

        // three-cycle glitch on bit 3 is rejected
        clean_reset();
        raw_i = 8'h08;
        step(3);
        raw_i = 8'h00;
        quiet("glitch3", 8, 8'h00, 8'h00);

        // four-cycle pulse on bit 3 is accepted, then falls back
        raw_i = 8'h08;
        quiet("glitch4_pre", 4, 8'h00, 8'h00);
        raw_i = 8'h00;
        step(1);
        chk("glitch4_sw_not_yet", sw_o, 8'h00);
        step(1);
        chk("glitch4_sw", sw_o, 8'h08);
        chk("glitch4_rise", rise_o, 8'h08);
        quiet("glitch4_hold", 3, 8'h08, 8'h08);
        step(1);
        chk("glitch4_fall", fall_o, 8'h08);
        chk("glitch4_sw_back", sw_o, 8'h00);

        // bounce on bit 5: 1,0,1,0 two cycles each, then held high
        clean_reset();
        for (int b = 0; b < 4; b++) begin
            raw_i = (b % 2 == 0) ? 8'h20 : 8'h00;
            quiet("bounce", 2, 8'h00, 8'h00);
        end
        raw_i = 8'h20;
        quiet("bounce_final", 5, 8'h00, 8'h00);
        step(1);
        chk("bounce_rise", rise_o, 8'h20);
        chk("bounce_sw", sw_o, 8'h20);
        quiet("bounce_after", 3, 8'h20, 8'h20);

        // sticky flag on bit 2: clear, selective clear, set beats clear
        clean_reset();
        raw_i = 8'h04;
        step(6);
        chk("evt2_set", evt_o, 8'h04);
        evt_clr_i = 8'h02;
        step(1);
        chk("evt2_other_clr", evt_o, 8'h04);
        evt_clr_i = 8'h04;
        step(1);
        chk("evt2_clr", evt_o, 8'h00);
        evt_clr_i = 8'hFF;
        step(1);
        chk("evt_clr_idle", evt_o, 8'h00);
        evt_clr_i = 8'h00;
        raw_i = 8'h00;
        step(5);
        chk("evt2_pre_fall", evt_o, 8'h00);
        evt_clr_i = 8'h04;
        step(1);
        chk("evt2_fall", fall_o, 8'h04);
        chk("evt2_set_wins", evt_o, 8'h04);
        evt_clr_i = 8'h00;
        step(1);
        chk("evt2_stays", evt_o, 8'h04);

        // reset in the middle of a debounce on bit 7
        clean_reset();
        raw_i = 8'h80;
        step(4);
        rst_i = 1'b1;
        step(2);
        chk("midrst_sw", sw_o, 8'h00);
        chk("midrst_rise", rise_o, 8'h00);
        rst_i = 1'b0;
        quiet("midrst_pre", 5, 8'h00, 8'h00);
        step(1);
        chk("midrst_rise7", rise_o, 8'h80);
        chk("midrst_sw7", sw_o, 8'h80);
        step(1);
        chk("midrst_rise_end", rise_o, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
